score_combo_ctrl: RTL and testbench
===================================

// Module: score_combo_ctrl
// PURPOSE
//  Downstream consumer of the judgement stage. Turns per-note judgement codes into a
//  game score, current/max combo and per-grade hit counts.
//  Runs a per-song IDLE/PLAY/DONE session FSM. Feeds the LCD/7-seg display and the result screen.
// PARAMETERS
//  SCORE_W    20   score width, bits; score saturates at 2**SCORE_W-1
//  CNT_W      10   width of combo, max-combo and per-grade counters; all saturate
//  PTS_PERF   100  base points for a PERFECT
//  PTS_NORM   50   base points for a NORMAL
//  COMBO_X2   10   combo (after increment) at which the multiplier becomes x2
//  COMBO_X3   30   combo (after increment) at which the multiplier becomes x3; must be > COMBO_X2
//  BCD_DIGITS 7    decimal digits of the BCD score (SCORE_BCD_EN only)
// PORTS
//  clk          in   1            system clock
//  rst          in   1            synchronous, active-high reset
//  i_judge      in   2            judgement code: 00 none, 01 miss, 10 normal, 11 perfect; level, cleared upstream each 1 ms tick
//  i_start      in   1            1-cycle pulse: clear all stats, enter PLAY
//  i_song_end   in   1            1-cycle pulse: song finished, enter DONE
//  o_score      out  SCORE_W      accumulated score
//  o_combo      out  CNT_W        current consecutive-hit count
//  o_max_combo  out  CNT_W        highest combo in this session
//  o_perf_cnt   out  CNT_W        PERFECT count
//  o_norm_cnt   out  CNT_W        NORMAL count
//  o_miss_cnt   out  CNT_W        MISS count
//  o_playing    out  1            1 while in PLAY
//  o_done       out  1            1 while in DONE
//  o_full_combo out  1            valid in DONE: miss_cnt==0 and perf_cnt+norm_cnt>0
//  o_score_bcd  out  4*BCD_DIGITS BCD of o_score (0 when macro off)
//  o_bcd_valid  out  1            o_score_bcd matches o_score (0 when macro off)
// BEHAVIOUR
//  - Reset: FSM=IDLE, judge_q=00, all counters/outputs 0.
//  - Event detect: judge_q <= i_judge every cycle. Event = (i_judge!=00) && (i_judge!=judge_q).
//    A held code counts once. Two identical codes need at least one 00 cycle between them.
//  - FSM: IDLE --i_start--> PLAY; PLAY --i_song_end--> DONE; DONE --i_start--> PLAY.
//    i_start in PLAY restarts: stats cleared, stay in PLAY. i_song_end outside PLAY is ignored.
//  - i_start clears score, combo, max_combo and all grade counters on the same edge.
//    Any event in that cycle is dropped.
//  - Events are counted only in PLAY. IDLE and DONE hold all stats.
//  - Event and i_song_end in the same cycle: the event is counted, then the FSM enters DONE.
//  - Hit (10/11): combo_n = sat(combo+1); mult = 3 if combo_n>=COMBO_X3, 2 if >=COMBO_X2, else 1.
//    score += mult*PTS, saturating, with the sum computed SCORE_W+2 bits wide.
//    Matching grade count +1 (saturating). max_combo = max(max_combo, combo_n).
//  - Miss (01): combo <= 0; miss_cnt +1 (saturating); score unchanged.
//  - Latency: every statistic output updates on the clock edge that samples the event (1 cycle).
//  - Saturated counters hold at all-ones and never wrap.
// CONFIGURATION
//  SCORE_BCD_EN defined:
//    - Sequential double-dabble converter runs in the background.
//    - Any change of o_score drops o_bcd_valid the next cycle and restarts conversion.
//    - Conversion takes SCORE_W+1 cycles; then o_score_bcd updates and o_bcd_valid=1.
//    - A score change mid-conversion aborts and restarts it.
//    - Reset: bcd=0, valid=1.
//  SCORE_BCD_EN undefined: no converter is built; o_score_bcd=0, o_bcd_valid=0 constantly.
// STRUCTURE
//  - Package rhythm_pkg: JUDGE_NONE/MISS/NORMAL/PERFECT codes and FSM state encodings.
//    The judgement stage and the display stages share the same package.
//  - Sub-module score_bin2bcd (SCORE_W, BCD_DIGITS): start/busy/done double-dabble.
//    Instantiated only under SCORE_BCD_EN.
// TESTING
//  1. rst; i_start; 11 held 5 cycles, 00, 11 -> perf_cnt=2, combo=2, score=200 (11 counted once per level change).
//  2. 10 consecutive PERFECTs, then 1 NORMAL -> score=900+200+100=1200, combo=11, max_combo=11.
//  3. PLAY: 3 hits, 01, 2 hits -> combo=2, max_combo=3, miss_cnt=1; i_song_end -> o_done=1, o_full_combo=0.
//  4. IDLE and DONE: 11/10/01 events -> no stat change. i_start with 11 in the same cycle -> all stats 0, o_playing=1.
//  5. SCORE_W=8, PTS_PERF=100: 3 PERFECTs -> o_score=255 (saturated), stays 255. CNT_W=2: 5 misses -> miss_cnt=3.
//  6. SCORE_BCD_EN: score 1200 -> o_bcd_valid low, after SCORE_W+1 cycles o_score_bcd=0x0001200, valid=1;
//     a new hit mid-conversion restarts it.

Source files
------------

// File: rtl/rhythm_pkg.sv
// Shared judgement codes and session-state encodings for the rhythm-game pipeline.
// Used by the judgement stage, score/combo controller and display stages.
package rhythm_pkg;

  typedef enum logic [1:0] {
    JUDGE_NONE    = 2'b00,
    JUDGE_MISS    = 2'b01,
    JUDGE_NORMAL  = 2'b10,
    JUDGE_PERFECT = 2'b11
  } judge_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/score_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter with a start/busy/done handshake.
// A start while busy aborts the running conversion and reloads the new value.
module score_bin2bcd #(
  parameter int SCORE_W    = 20,
  parameter int BCD_DIGITS = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [SCORE_W-1:0]      i_bin,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [4*BCD_DIGITS-1:0] o_bcd
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int SH_W  = BCD_W + SCORE_W;
  localparam int CW    = $clog2(SCORE_W + 1);

  logic [SH_W-1:0]  sh_q, sh_d, adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    adj = sh_q;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (adj[SCORE_W+4*d +: 4] >= 4'd5) adj[SCORE_W+4*d +: 4] = adj[SCORE_W+4*d +: 4] + 4'd3;
    end

    sh_d   = sh_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    bcd_d  = bcd_q;
    if (i_start) begin
      sh_d   = {{BCD_W{1'b0}}, i_bin};
      cnt_d  = CW'(SCORE_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        sh_d  = adj << 1;
        cnt_d = cnt_q - 1'b1;
      end else begin
        busy_d = 1'b0;
        bcd_d  = sh_q[SH_W-1 -: BCD_W];
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      bcd_q  <= '0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      bcd_q  <= bcd_d;
    end
  end

  assign o_busy = busy_q;
  assign o_done = busy_q && (cnt_q == '0);
  assign o_bcd  = bcd_q;

endmodule

// File: rtl/score_combo_ctrl.sv
// Score / combo / grade-count controller with IDLE-PLAY-DONE session FSM.
// Optional background BCD conversion of the score is enabled with `define SCORE_BCD_EN.
module score_combo_ctrl
  import rhythm_pkg::*;
#(
  parameter int SCORE_W    = 20,
  parameter int CNT_W      = 10,
  parameter int PTS_PERF   = 100,
  parameter int PTS_NORM   = 50,
  parameter int COMBO_X2   = 10,
  parameter int COMBO_X3   = 30,
  parameter int BCD_DIGITS = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              i_judge,
  input  logic                    i_start,
  input  logic                    i_song_end,
  output logic [SCORE_W-1:0]      o_score,
  output logic [CNT_W-1:0]        o_combo,
  output logic [CNT_W-1:0]        o_max_combo,
  output logic [CNT_W-1:0]        o_perf_cnt,
  output logic [CNT_W-1:0]        o_norm_cnt,
  output logic [CNT_W-1:0]        o_miss_cnt,
  output logic                    o_playing,
  output logic                    o_done,
  output logic                    o_full_combo,
  output logic [4*BCD_DIGITS-1:0] o_score_bcd,
  output logic                    o_bcd_valid
);

  localparam int SW2 = SCORE_W + 2;

  state_e             state_q, state_d;
  logic [1:0]         judge_q, judge_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [CNT_W-1:0]   combo_q, combo_d, max_q, max_d;
  logic [CNT_W-1:0]   perf_q, perf_d, norm_q, norm_d, miss_q, miss_d;

  logic               is_event, is_hit;
  logic [CNT_W-1:0]   combo_inc;
  logic [31:0]        combo_ext;
  logic [SW2-1:0]     pts_w, add_w, sum_w;

  assign is_event  = (i_judge != JUDGE_NONE) && (i_judge != judge_q);
  assign is_hit    = (i_judge == JUDGE_NORMAL) || (i_judge == JUDGE_PERFECT);
  assign combo_inc = (&combo_q) ? combo_q : combo_q + 1'b1;
  assign combo_ext = 32'(combo_inc);
  assign pts_w     = (i_judge == JUDGE_PERFECT) ? SW2'(PTS_PERF) : SW2'(PTS_NORM);
  assign add_w     = (combo_ext >= 32'(COMBO_X3)) ? pts_w + (pts_w << 1) :
                     (combo_ext >= 32'(COMBO_X2)) ? (pts_w << 1) : pts_w;
  assign sum_w     = {2'b00, score_q} + add_w;

  always_comb begin
    state_d = state_q;
    judge_d = i_judge;
    score_d = score_q;
    combo_d = combo_q;
    max_d   = max_q;
    perf_d  = perf_q;
    norm_d  = norm_q;
    miss_d  = miss_q;

    case (state_q)
      ST_IDLE: if (i_start) state_d = ST_PLAY;
      ST_PLAY: if (!i_start && i_song_end) state_d = ST_DONE;
      ST_DONE: if (i_start) state_d = ST_PLAY;
      default: state_d = ST_IDLE;
    endcase

    // A start wins over any event sampled on the same edge.
    if (i_start) begin
      score_d = '0;
      combo_d = '0;
      max_d   = '0;
      perf_d  = '0;
      norm_d  = '0;
      miss_d  = '0;
    end else if (state_q == ST_PLAY && is_event) begin
      if (is_hit) begin
        combo_d = combo_inc;
        score_d = (sum_w > {2'b00, {SCORE_W{1'b1}}}) ? {SCORE_W{1'b1}} : sum_w[SCORE_W-1:0];
        if (combo_inc > max_q) max_d = combo_inc;
        if (i_judge == JUDGE_PERFECT) begin
          if (!(&perf_q)) perf_d = perf_q + 1'b1;
        end else begin
          if (!(&norm_q)) norm_d = norm_q + 1'b1;
        end
      end else begin
        combo_d = '0;
        if (!(&miss_q)) miss_d = miss_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      judge_q <= 2'b00;
      score_q <= '0;
      combo_q <= '0;
      max_q   <= '0;
      perf_q  <= '0;
      norm_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      judge_q <= judge_d;
      score_q <= score_d;
      combo_q <= combo_d;
      max_q   <= max_d;
      perf_q  <= perf_d;
      norm_q  <= norm_d;
      miss_q  <= miss_d;
    end
  end

  assign o_score      = score_q;
  assign o_combo      = combo_q;
  assign o_max_combo  = max_q;
  assign o_perf_cnt   = perf_q;
  assign o_norm_cnt   = norm_q;
  assign o_miss_cnt   = miss_q;
  assign o_playing    = (state_q == ST_PLAY);
  assign o_done       = (state_q == ST_DONE);
  assign o_full_combo = (state_q == ST_DONE) && (miss_q == '0) && ((perf_q != '0) || (norm_q != '0));

`ifdef SCORE_BCD_EN
  logic [SCORE_W-1:0] seen_q, seen_d;
  logic               valid_q, valid_d;
  logic               conv_start, conv_busy, conv_done;

  // A score change seen one cycle late restarts the converter and invalidates the display.
  assign conv_start = (score_q != seen_q);

  always_comb begin
    seen_d  = score_q;
    valid_d = valid_q;
    if (conv_start)     valid_d = 1'b0;
    else if (conv_done) valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seen_q  <= '0;
      valid_q <= 1'b1;
    end else begin
      seen_q  <= seen_d;
      valid_q <= valid_d;
    end
  end

  score_bin2bcd #(
    .SCORE_W   (SCORE_W),
    .BCD_DIGITS(BCD_DIGITS)
  ) u_bin2bcd (
    .clk    (clk),
    .rst    (rst),
    .i_start(conv_start),
    .i_bin  (score_q),
    .o_busy (conv_busy),
    .o_done (conv_done),
    .o_bcd  (o_score_bcd)
  );

  assign o_bcd_valid = valid_q && !conv_busy;
`else
  assign o_score_bcd = '0;
  assign o_bcd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_score_combo_ctrl.sv
// Self-checking bench for score_combo_ctrl: per-cycle scoreboard against a behavioural model,
// plus directed checks of the documented scenarios (define SCORE_BCD_EN to cover the BCD path).
module tb_score_combo_ctrl;
  import rhythm_pkg::*;

  localparam int SW = 20;
  localparam int CW = 10;
  localparam int BD = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    i_judge = 2'b00;
  logic          i_start = 1'b0;
  logic          i_song_end = 1'b0;
  logic [SW-1:0] o_score;
  logic [CW-1:0] o_combo, o_max_combo, o_perf_cnt, o_norm_cnt, o_miss_cnt;
  logic          o_playing, o_done, o_full_combo, o_bcd_valid;
  logic [4*BD-1:0] o_score_bcd;

  // Small-width instance for saturation behaviour.
  logic [1:0]    s_judge = 2'b00;
  logic          s_start = 1'b0;
  logic          s_song_end = 1'b0;
  logic [7:0]    s_score;
  logic [1:0]    s_combo, s_max_combo, s_perf_cnt, s_norm_cnt, s_miss_cnt;
  logic          s_playing, s_done, s_full_combo, s_bcd_valid;
  logic [4*BD-1:0] s_score_bcd;

  always #5 clk = ~clk;

  score_combo_ctrl #(
    .SCORE_W(SW), .CNT_W(CW), .PTS_PERF(100), .PTS_NORM(50),
    .COMBO_X2(10), .COMBO_X3(30), .BCD_DIGITS(BD)
  ) dut (
    .clk(clk), .rst(rst), .i_judge(i_judge), .i_start(i_start), .i_song_end(i_song_end),
    .o_score(o_score), .o_combo(o_combo), .o_max_combo(o_max_combo),
    .o_perf_cnt(o_perf_cnt), .o_norm_cnt(o_norm_cnt), .o_miss_cnt(o_miss_cnt),
    .o_playing(o_playing), .o_done(o_done), .o_full_combo(o_full_combo),
    .o_score_bcd(o_score_bcd), .o_bcd_valid(o_bcd_valid)
  );

  score_combo_ctrl #(
    .SCORE_W(8), .CNT_W(2), .PTS_PERF(100), .PTS_NORM(50),
    .COMBO_X2(10), .COMBO_X3(30), .BCD_DIGITS(BD)
  ) dut_small (
    .clk(clk), .rst(rst), .i_judge(s_judge), .i_start(s_start), .i_song_end(s_song_end),
    .o_score(s_score), .o_combo(s_combo), .o_max_combo(s_max_combo),
    .o_perf_cnt(s_perf_cnt), .o_norm_cnt(s_norm_cnt), .o_miss_cnt(s_miss_cnt),
    .o_playing(s_playing), .o_done(s_done), .o_full_combo(s_full_combo),
    .o_score_bcd(s_score_bcd), .o_bcd_valid(s_bcd_valid)
  );

  typedef struct packed {
    logic [SW-1:0] score;
    logic [CW-1:0] combo;
    logic [CW-1:0] maxc;
    logic [CW-1:0] perf;
    logic [CW-1:0] norm;
    logic [CW-1:0] miss;
    logic          playing;
    logic          done;
    logic          full;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Behavioural model state.
  logic [1:0] m_jq;
  int m_state, m_score, m_combo, m_maxc, m_perf, m_norm, m_miss;

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  task automatic model_reset();
    m_jq = 2'b00; m_state = 0;
    m_score = 0; m_combo = 0; m_maxc = 0; m_perf = 0; m_norm = 0; m_miss = 0;
  endtask

  // Drive one cycle, push the model's expectation, then pop and compare after the edge.
  task automatic apply(input logic [1:0] j, input logic st, input logic en);
    logic ev;
    int   c, mult;
    exp_t e, a;
    i_judge = j; i_start = st; i_song_end = en;
    ev = (j != 2'b00) && (j != m_jq);
    m_jq = j;
    if (st) begin
      m_score = 0; m_combo = 0; m_maxc = 0; m_perf = 0; m_norm = 0; m_miss = 0;
      m_state = 1;
    end else if (m_state == 1) begin
      if (ev) begin
        if (j == 2'b01) begin
          m_combo = 0;
          m_miss  = sat(m_miss + 1, CW);
        end else begin
          c = sat(m_combo + 1, CW);
          mult = (c >= 30) ? 3 : (c >= 10) ? 2 : 1;
          m_score = sat(m_score + mult * ((j == 2'b11) ? 100 : 50), SW);
          m_combo = c;
          if (c > m_maxc) m_maxc = c;
          if (j == 2'b11) m_perf = sat(m_perf + 1, CW);
          else            m_norm = sat(m_norm + 1, CW);
        end
      end
      if (en) m_state = 2;
    end
    e.score = SW'(m_score); e.combo = CW'(m_combo); e.maxc = CW'(m_maxc);
    e.perf = CW'(m_perf); e.norm = CW'(m_norm); e.miss = CW'(m_miss);
    e.playing = (m_state == 1); e.done = (m_state == 2);
    e.full = (m_state == 2) && (m_miss == 0) && (m_perf + m_norm > 0);
    sb_q.push_back(e);

    @(posedge clk); #1;
    e = sb_q.pop_front();
    a.score = o_score; a.combo = o_combo; a.maxc = o_max_combo;
    a.perf = o_perf_cnt; a.norm = o_norm_cnt; a.miss = o_miss_cnt;
    a.playing = o_playing; a.done = o_done; a.full = o_full_combo;
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL sb_vec%0d got sc=%0d cb=%0d mx=%0d p=%0d n=%0d m=%0d pl=%b dn=%b fc=%b required sc=%0d cb=%0d mx=%0d p=%0d n=%0d m=%0d pl=%b dn=%b fc=%b",
               vectors, a.score, a.combo, a.maxc, a.perf, a.norm, a.miss, a.playing, a.done, a.full,
               e.score, e.combo, e.maxc, e.perf, e.norm, e.miss, e.playing, e.done, e.full);
    end
    i_start = 1'b0; i_song_end = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_judge = 2'b11; i_start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({o_score, o_combo, o_max_combo, o_perf_cnt, o_norm_cnt, o_miss_cnt} !== '0 ||
        {o_playing, o_done, o_full_combo} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_stats got sc=%0d cb=%0d p=%0d m=%0d pl=%b dn=%b required all 0",
               o_score, o_combo, o_perf_cnt, o_miss_cnt, o_playing, o_done);
    end
    vectors++;
`ifdef SCORE_BCD_EN
    if (o_score_bcd !== '0 || o_bcd_valid !== 1'b1) begin
`else
    if (o_score_bcd !== '0 || o_bcd_valid !== 1'b0) begin
`endif
      miscompares++;
      $display("FAIL reset_bcd got bcd=%h valid=%b", o_score_bcd, o_bcd_valid);
    end
    i_judge = 2'b00; i_start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_idle();
    apply(2'b11, 1'b0, 1'b0);
    apply(2'b10, 1'b0, 1'b1);
    apply(2'b01, 1'b0, 1'b0);
    apply(2'b00, 1'b0, 1'b0);
    vectors++;
    if (o_playing !== 1'b0 || o_done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_state got playing=%b done=%b required 0 0", o_playing, o_done);
    end
  endtask

  task automatic test_hold();
    apply(2'b00, 1'b1, 1'b0);
    repeat (5) apply(2'b11, 1'b0, 1'b0);
    apply(2'b00, 1'b0, 1'b0);
    apply(2'b11, 1'b0, 1'b0);
    vectors++;
    if (o_perf_cnt !== 10'd2 || o_combo !== 10'd2 || o_score !== 20'd200) begin
      miscompares++;
      $display("FAIL hold_once got perf=%0d combo=%0d score=%0d required 2 2 200", o_perf_cnt, o_combo, o_score);
    end
    apply(2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_multiplier();
    apply(2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      apply(2'b11, 1'b0, 1'b0);
      apply(2'b00, 1'b0, 1'b0);
    end
    apply(2'b10, 1'b0, 1'b0);
    vectors++;
    if (o_score !== 20'd1200 || o_combo !== 10'd11 || o_max_combo !== 10'd11) begin
      miscompares++;
      $display("FAIL mult_x2 got score=%0d combo=%0d max=%0d required 1200 11 11", o_score, o_combo, o_max_combo);
    end
  endtask

  task automatic test_x3_boundary();
    apply(2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 29; i++) begin
      apply(2'b11, 1'b0, 1'b0);
      apply(2'b00, 1'b0, 1'b0);
    end
    vectors++;
    if (o_score !== 20'd4900 || o_combo !== 10'd29) begin
      miscompares++;
      $display("FAIL x3_before got score=%0d combo=%0d required 4900 29", o_score, o_combo);
    end
    apply(2'b11, 1'b0, 1'b0);
    vectors++;
    if (o_score !== 20'd5200 || o_combo !== 10'd30) begin
      miscompares++;
      $display("FAIL x3_at got score=%0d combo=%0d required 5200 30", o_score, o_combo);
    end
    apply(2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_miss_done();
    apply(2'b00, 1'b1, 1'b0);
    apply(2'b11, 1'b0, 1'b0);
    apply(2'b10, 1'b0, 1'b0);
    apply(2'b11, 1'b0, 1'b0);
    apply(2'b01, 1'b0, 1'b0);
    apply(2'b11, 1'b0, 1'b0);
    apply(2'b10, 1'b0, 1'b0);
    vectors++;
    if (o_combo !== 10'd2 || o_max_combo !== 10'd3 || o_miss_cnt !== 10'd1) begin
      miscompares++;
      $display("FAIL miss_combo got combo=%0d max=%0d miss=%0d required 2 3 1", o_combo, o_max_combo, o_miss_cnt);
    end
    apply(2'b00, 1'b0, 1'b1);
    vectors++;
    if (o_done !== 1'b1 || o_full_combo !== 1'b0 || o_playing !== 1'b0) begin
      miscompares++;
      $display("FAIL miss_done got done=%b full=%b playing=%b required 1 0 0", o_done, o_full_combo, o_playing);
    end
  endtask

  task automatic test_done_hold_restart();
    apply(2'b11, 1'b0, 1'b0);
    apply(2'b10, 1'b0, 1'b1);
    apply(2'b01, 1'b0, 1'b0);
    apply(2'b11, 1'b1, 1'b0);
    vectors++;
    if ({o_score, o_combo, o_max_combo, o_perf_cnt, o_norm_cnt, o_miss_cnt} !== '0 || o_playing !== 1'b1) begin
      miscompares++;
      $display("FAIL start_clear got score=%0d perf=%0d miss=%0d playing=%b required 0 0 0 1",
               o_score, o_perf_cnt, o_miss_cnt, o_playing);
    end
    apply(2'b11, 1'b0, 1'b0);
    apply(2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_song_end_event();
    apply(2'b00, 1'b1, 1'b0);
    apply(2'b11, 1'b0, 1'b1);
    vectors++;
    if (o_perf_cnt !== 10'd1 || o_done !== 1'b1 || o_full_combo !== 1'b1) begin
      miscompares++;
      $display("FAIL end_with_event got perf=%0d done=%b full=%b required 1 1 1", o_perf_cnt, o_done, o_full_combo);
    end
    apply(2'b00, 1'b1, 1'b0);
    apply(2'b00, 1'b0, 1'b1);
    vectors++;
    if (o_full_combo !== 1'b0 || o_done !== 1'b1) begin
      miscompares++;
      $display("FAIL empty_full_combo got full=%b done=%b required 0 1", o_full_combo, o_done);
    end
  endtask

  task automatic test_restart_in_play();
    apply(2'b00, 1'b1, 1'b0);
    apply(2'b11, 1'b0, 1'b0);
    apply(2'b01, 1'b0, 1'b0);
    apply(2'b10, 1'b0, 1'b0);
    apply(2'b00, 1'b1, 1'b0);
    vectors++;
    if (o_score !== '0 || o_miss_cnt !== '0 || o_playing !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_play got score=%0d miss=%0d playing=%b required 0 0 1", o_score, o_miss_cnt, o_playing);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] exp_sc [4];
    exp_sc[0] = 8'd100; exp_sc[1] = 8'd200; exp_sc[2] = 8'd255; exp_sc[3] = 8'd255;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_judge = 2'b11;
      @(posedge clk); #1;
      vectors++;
      if (s_score !== exp_sc[i]) begin
        miscompares++;
        $display("FAIL sat_score%0d got %0d required %0d", i, s_score, exp_sc[i]);
      end
      s_judge = 2'b00;
      @(posedge clk); #1;
    end
    vectors++;
    if (s_perf_cnt !== 2'd3 || s_combo !== 2'd3 || s_max_combo !== 2'd3) begin
      miscompares++;
      $display("FAIL sat_counts got perf=%0d combo=%0d max=%0d required 3 3 3", s_perf_cnt, s_combo, s_max_combo);
    end
    for (int i = 0; i < 5; i++) begin
      s_judge = 2'b01;
      @(posedge clk); #1;
      s_judge = 2'b00;
      @(posedge clk); #1;
    end
    vectors++;
    if (s_miss_cnt !== 2'd3 || s_combo !== 2'd0 || s_score !== 8'd255) begin
      miscompares++;
      $display("FAIL sat_miss got miss=%0d combo=%0d score=%0d required 3 0 255", s_miss_cnt, s_combo, s_score);
    end
  endtask

`ifdef SCORE_BCD_EN
  task automatic wait_bcd(input logic [4*BD-1:0] exp_bcd, input string tag);
    int n;
    @(posedge clk); #1;
    vectors++;
    if (o_bcd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_drop got valid=%b required 0", tag, o_bcd_valid);
    end
    n = 0;
    while (o_bcd_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (n != SW + 1 || o_score_bcd !== exp_bcd) begin
      miscompares++;
      $display("FAIL %s_conv got cycles=%0d bcd=%h required cycles=%0d bcd=%h", tag, n, o_score_bcd, SW + 1, exp_bcd);
    end
  endtask

  task automatic test_bcd();
    test_multiplier();
    wait_bcd(28'h0001200, "bcd1200");
    apply(2'b00, 1'b0, 1'b0);
    apply(2'b11, 1'b0, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    apply(2'b00, 1'b0, 1'b0);
    apply(2'b11, 1'b0, 1'b0);
    wait_bcd(28'h0001600, "bcd_restart");
  endtask
`else
  task automatic test_bcd();
    test_multiplier();
    repeat (25) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (o_score_bcd !== '0 || o_bcd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bcd_off got bcd=%h valid=%b required 0 0", o_score_bcd, o_bcd_valid);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle();
    test_hold();
    test_multiplier();
    test_x3_boundary();
    test_miss_done();
    test_done_hold_restart();
    test_song_end_event();
    test_restart_in_play();
    test_saturation();
    test_bcd();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
